// File: rtl/fifo_reader.sv
// Read-side adapter: drains the synchronous fifo into a valid/ready stream through a 2-entry skid buffer.
// Define FIFO_READER_STATS_EN to add the words_out / stall_cycles statistics outputs.
module fifo_reader #(
  parameter int FIFO_WIDTH  = 4,
  parameter int N_ADDR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  rd_en,
  output logic                  out_valid,
  output logic [FIFO_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]           words_out,
  output logic [15:0]           stall_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  state;
  occ_t                  state_next;
  logic                  inflight;
  logic                  land;
  logic                  pop;
  logic [1:0]            held;
  logic [FIFO_WIDTH-1:0] buf0;
  logic [FIFO_WIDTH-1:0] buf1;
  logic [FIFO_WIDTH-1:0] buf0_next;
  logic [FIFO_WIDTH-1:0] buf1_next;

  // The statistics counters are 16 bits wide, so the fifo they watch must stay addressable within that range.
  if (N_ADDR_BITS < 1 || N_ADDR_BITS > 16) begin : g_addr_bits_check
    $error("fifo_reader: N_ADDR_BITS out of range");
  end

  // State register: occupancy, read-in-flight flag and the two buffer slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      state    <= state_next;
      inflight <= rd_en;
      buf0     <= buf0_next;
      buf1     <= buf1_next;
    end
  end

  // Next-state logic: a word lands the cycle after rd_en; buf0 is always the head.
  always_comb begin
    state_next = state;
    buf0_next  = buf0;
    buf1_next  = buf1;
    land       = inflight;
    case (state)
      EMPTY: begin
        if (land) begin
          state_next = ONE;
          buf0_next  = fifo_rd_data;
        end else begin
          state_next = EMPTY;
        end
      end
      ONE: begin
        if (land && !pop) begin
          state_next = TWO;
          buf1_next  = fifo_rd_data;
        end else if (land && pop) begin
          state_next = ONE;
          buf0_next  = fifo_rd_data;
        end else if (pop) begin
          state_next = EMPTY;
        end else begin
          state_next = ONE;
        end
      end
      TWO: begin
        // Land without pop cannot happen here: rd_en is withheld once two words are owned.
        if (pop) begin
          buf0_next = buf1;
          if (land) begin
            state_next = TWO;
            buf1_next  = fifo_rd_data;
          end else begin
            state_next = ONE;
          end
        end else begin
          state_next = TWO;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Output logic: stream handshake and read issue; out_ready feeds rd_en combinationally.
  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = buf0;
    busy      = inflight | (state != EMPTY);
    pop       = out_valid & out_ready;
    held      = state + {1'b0, inflight} - {1'b0, pop};
    rd_en     = !reset & !fifo_empty & (held < 2'd2);
  end

`ifdef FIFO_READER_STATS_EN
  // Statistics: pop count wraps, stall count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_out    <= 16'd0;
      stall_cycles <= 16'd0;
    end else begin
      if (pop) begin
        words_out <= words_out + 16'd1;
      end else begin
        words_out <= words_out;
      end
      if (out_valid && !out_ready && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
    end
  end
`endif

endmodule
